// File: rtl/motoro3_pwm_multi_if.sv
// Bus between the commutation sequencer and the multi-channel PWM generator.
// The master side drives period/duty/enables/sync, and the slave side returns the gate drives.
interface motoro3_pwm_multi_if #(
    parameter int CW = 12,
    parameter int CH = 3
);
    logic [CW-1:0]    period;
    logic [CH*CW-1:0] duty;
    logic             dutyLoad;
    logic [CH-1:0]    en;
    logic             syncIn;
    logic [CH-1:0]    pwmH;
    logic [CH-1:0]    pwmL;
    logic             periodEnd;

    modport master (
        output period, duty, dutyLoad, en, syncIn,
        input  pwmH, pwmL, periodEnd
    );

    modport slave (
        input  period, duty, dutyLoad, en, syncIn,
        output pwmH, pwmL, periodEnd
    );
endinterface

// File: rtl/motoro3_pwm_multi.sv
// Multi-channel edge-aligned PWM with shared period counter, shadowed duty and min-on clamp.
// Define MOTORO3_PWM_DEADTIME_EN for complementary low-side outputs with DT dead time.
module motoro3_pwm_multi #(
    parameter int CW     = 12,
    parameter int CH     = 3,
    parameter int MIN_ON = 32,
    parameter int DT     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    motoro3_pwm_multi_if.slave     bus
);
    localparam int EW = CW + 1;

    logic [CW-1:0]          r_cnt_p0;
    logic [CW-1:0]          r_pAct;
    logic [CH-1:0][CW-1:0]  r_dAct;
    logic [CH-1:0]          r_full;
    logic [CW-1:0]          r_pPend;
    logic [CH-1:0][CW-1:0]  r_dPend;
    logic                   r_pendValid;
    logic                   r_periodEnd_p1;
    logic [CH-1:0]          r_pwmH_p1;

    logic                   w_enAny;
    logic                   w_boundary;
    logic                   w_ldValid;
    logic                   w_xfer;
    logic [CW-1:0]          w_pSrc;
    logic [CH-1:0][CW-1:0]  w_dSrc;
    logic [CW-1:0]          w_pNew;
    logic [CH-1:0][CW:0]    w_dNew;
    logic [CH-1:0]          w_raw;

    function automatic logic [CW-1:0] clamp_period(input logic [CW-1:0] p);
        if ({1'b0, p} < EW'(2 * MIN_ON))
            return CW'(2 * MIN_ON);
        return p;
    endfunction

    // Returns {full_on, duty}; full_on marks the no-edge 100 % case.
    function automatic logic [CW:0] clamp_duty(input logic [CW-1:0] d, input logic [CW-1:0] p);
        logic [CW:0] w_hi;
        w_hi = {1'b0, p} - EW'(MIN_ON) + EW'(1);
        if (d == '0)
            return '0;
        else if ({1'b0, d} > {1'b0, p})
            return {1'b1, d};
        else if ({1'b0, d} < EW'(MIN_ON))
            return {1'b0, CW'(MIN_ON)};
        else if ({1'b0, d} > w_hi)
            return {1'b0, w_hi[CW-1:0]};
        return {1'b0, d};
    endfunction

    assign w_enAny    = |bus.en;
    assign w_boundary = (r_cnt_p0 == r_pAct) | bus.syncIn;
    assign w_ldValid  = bus.dutyLoad | r_pendValid;
    // With every channel off the shadow set is applied straight away.
    assign w_xfer     = w_ldValid & (w_boundary | ~w_enAny);
    assign w_pSrc     = bus.dutyLoad ? bus.period : r_pPend;
    assign w_dSrc     = bus.dutyLoad ? bus.duty : r_dPend;
    assign w_pNew     = clamp_period(w_pSrc);

    always_comb begin
        w_dNew = '0;
        w_raw  = '0;
        for (int i = 0; i < CH; i++) begin
            w_dNew[i] = clamp_duty(w_dSrc[i], w_pNew);
            w_raw[i]  = bus.en[i] & (r_full[i] | (r_cnt_p0 < r_dAct[i]));
        end
    end

    // Stage p0: counter, shadow transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_p0       <= '0;
            r_pendValid    <= 1'b0;
            r_pAct         <= '1;
            r_dAct         <= '0;
            r_full         <= '0;
            r_periodEnd_p1 <= 1'b0;
        end else begin
            if (!w_enAny || w_boundary)
                r_cnt_p0 <= '0;
            else
                r_cnt_p0 <= r_cnt_p0 + CW'(1);
            r_periodEnd_p1 <= w_boundary & w_enAny;
            if (w_xfer)
                r_pendValid <= 1'b0;
            else if (bus.dutyLoad)
                r_pendValid <= 1'b1;
            if (w_xfer) begin
                r_pAct <= w_pNew;
                for (int i = 0; i < CH; i++) begin
                    r_full[i] <= w_dNew[i][CW];
                    r_dAct[i] <= w_dNew[i][CW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.dutyLoad) begin
            r_pPend <= bus.period;
            r_dPend <= bus.duty;
        end
    end

    if (DT < 1 || DT > 255) begin : g_dt_out_of_range
        logic w_dtInvalid;
        assign w_dtInvalid = 1'b1;
    end

`ifdef MOTORO3_PWM_DEADTIME_EN
    logic [CH-1:0]        r_pwmL_p1;
    logic [CH-1:0]        r_tgt;
    logic [CH-1:0]        r_off;
    logic [CH-1:0][7:0]   r_dt;

    // Stage p1: dead-time insertion; any change of target restarts the gap with both sides low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwmH_p1 <= '0;
            r_pwmL_p1 <= '0;
            r_tgt     <= '0;
            r_off     <= '1;
            r_dt      <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (!bus.en[i]) begin
                    r_pwmH_p1[i] <= 1'b0;
                    r_pwmL_p1[i] <= 1'b0;
                    r_off[i]     <= 1'b1;
                    r_dt[i]      <= '0;
                end else if (r_off[i] || (w_raw[i] != r_tgt[i])) begin
                    r_tgt[i]     <= w_raw[i];
                    r_off[i]     <= 1'b0;
                    r_pwmH_p1[i] <= 1'b0;
                    r_pwmL_p1[i] <= 1'b0;
                    r_dt[i]      <= 8'(DT);
                end else if (r_dt[i] > 8'd1) begin
                    r_dt[i] <= r_dt[i] - 8'd1;
                end else if (r_dt[i] == 8'd1) begin
                    r_dt[i]      <= '0;
                    r_pwmH_p1[i] <= r_tgt[i];
                    r_pwmL_p1[i] <= ~r_tgt[i];
                end
            end
        end
    end

    assign bus.pwmL = r_pwmL_p1;
`else
    // Stage p1: registered raw compare
    always_ff @(posedge clk) begin
        if (rst)
            r_pwmH_p1 <= '0;
        else
            r_pwmH_p1 <= w_raw;
    end

    assign bus.pwmL = '0;
`endif

    assign bus.pwmH      = r_pwmH_p1;
    assign bus.periodEnd = r_periodEnd_p1;
endmodule

// File: tb/tb_motoro3_pwm_multi.sv
// Directed bench for motoro3_pwm_multi; dead-time steps run when MOTORO3_PWM_DEADTIME_EN is defined.
`timescale 1ns/1ps
module tb_motoro3_pwm_multi;
    localparam int CW = 12;
    localparam int CH = 3;

    logic clk = 1'b0;
    logic rst;
    always #50 clk = ~clk;

    motoro3_pwm_multi_if #(.CW(CW), .CH(CH)) bus ();

    motoro3_pwm_multi #(.CW(CW), .CH(CH), .MIN_ON(32), .DT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   hi[CH];
    int   pe;
    int   edges0;
    int   lOn = 0;
    int   ovl = 0;
    logic prev0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) hi[i] += int'(bus.pwmH[i]);
        pe += int'(bus.periodEnd);
        if (bus.pwmH[0] != prev0) edges0++;
        prev0 = bus.pwmH[0];
        if (bus.pwmL != '0) lOn++;
        if ((bus.pwmH & bus.pwmL) != '0) ovl++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        for (int i = 0; i < CH; i++) hi[i] = 0;
        pe     = 0;
        edges0 = 0;
        prev0  = bus.pwmH[0];
    endtask

    task automatic load(input logic [CW-1:0] p, input logic [CW-1:0] d2,
                        input logic [CW-1:0] d1, input logic [CW-1:0] d0);
        bus.period   = p;
        bus.duty     = {d2, d1, d0};
        bus.dutyLoad = 1'b1;
        tick();
        bus.dutyLoad = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.period   = '0;
        bus.duty     = '0;
        bus.dutyLoad = 1'b0;
        bus.en       = '0;
        bus.syncIn   = 1'b0;
        clr();
        ticks(3);
        chk("rst_pwmH", int'(bus.pwmH), 0);
        chk("rst_pwmL", int'(bus.pwmL), 0);
        chk("rst_periodEnd", int'(bus.periodEnd), 0);
        rst = 1'b0;
        tick();

`ifdef MOTORO3_PWM_DEADTIME_EN
        load(12'd511, 12'd0, 12'd0, 12'd256);
        bus.en = 3'b001;
        tick();
        chk("dt_start_pwmL0", int'(bus.pwmL[0]), 0);
        chk("dt_start_pwmH0", int'(bus.pwmH[0]), 0);
        clr();
        ticks(7);
        chk("dt_gap_pwmH0", int'(bus.pwmH[0]), 0);
        tick();
        chk("dt_rise_pwmH0", int'(bus.pwmH[0]), 1);
        chk("dt_rise_pwmL0", int'(bus.pwmL[0]), 0);
        ticks(503);
        chk("dt_hi0", hi[0], 248);
        chk("dt_pwmL0_back", int'(bus.pwmL[0]), 1);
        chk("dt_overlap", ovl, 0);
        bus.en = 3'b000;
        tick();
        chk("dt_en_off", int'(bus.pwmH | bus.pwmL), 0);
`else
        bus.en = 3'b111;
        clr();
        ticks(50);
        chk("noload_hi", hi[0] + hi[1] + hi[2], 0);
        bus.en = 3'b000;
        tick();
        load(12'd511, 12'd0, 12'd128, 12'd256);
        bus.en = 3'b111;
        clr();
        ticks(512);
        chk("p1_hi0", hi[0], 256);
        chk("p1_hi1", hi[1], 128);
        chk("p1_hi2", hi[2], 0);
        chk("p1_pe", pe, 1);
        chk("p1_pe_last", int'(bus.periodEnd), 1);
        clr();
        ticks(512);
        chk("p2_hi0", hi[0], 256);
        chk("p2_pe", pe, 1);

        ticks(100);
        clr();
        load(12'd511, 12'd0, 12'd128, 12'd10);
        ticks(411);
        chk("shadow_hi0", hi[0], 156);
        chk("shadow_pe", pe, 1);
        clr();
        ticks(512);
        chk("minon_hi0", hi[0], 32);
        chk("minon_hi1", hi[1], 128);
        chk("minon_pe", pe, 1);

        clr();
        load(12'd511, 12'd0, 12'd128, 12'd600);
        ticks(511);
        chk("pre100_hi0", hi[0], 32);
        clr();
        ticks(512);
        chk("full_hi0", hi[0], 512);
        clr();
        ticks(512);
        chk("full_edges0", edges0, 0);

        ticks(100);
        bus.syncIn = 1'b1;
        load(12'd511, 12'd0, 12'd128, 12'd64);
        bus.syncIn = 1'b0;
        chk("sync_pe", int'(bus.periodEnd), 1);
        clr();
        ticks(512);
        chk("sync_hi0", hi[0], 64);
        chk("sync_hi1", hi[1], 128);
        chk("sync_pe_once", pe, 1);

        clr();
        ticks(511);
        bus.syncIn = 1'b1;
        tick();
        bus.syncIn = 1'b0;
        tick();
        chk("sync_wrap_pe", pe, 1);

        ticks(10);
        chk("en111_pwmH", int'(bus.pwmH), 3'b011);
        bus.en = 3'b010;
        tick();
        chk("en010_pwmH", int'(bus.pwmH), 3'b010);
        bus.en = 3'b000;
        tick();
        chk("en000_pwmH", int'(bus.pwmH), 0);
        clr();
        ticks(600);
        chk("en000_hi", hi[0] + hi[1] + hi[2], 0);
        chk("en000_pe", pe, 0);
        bus.en = 3'b111;
        clr();
        ticks(512);
        chk("restart_hi0", hi[0], 64);
        chk("restart_pe", pe, 1);
        chk("restart_pe_last", int'(bus.periodEnd), 1);

        load(12'd511, 12'd0, 12'd400, 12'd600);
        ticks(511);
        ticks(299);
        load(12'd511, 12'd0, 12'd0, 12'd50);
        chk("prerst_pwmH", int'(bus.pwmH), 3'b011);
        rst = 1'b1;
        tick();
        chk("midrst_pwmH", int'(bus.pwmH), 0);
        chk("midrst_pwmL", int'(bus.pwmL), 0);
        chk("midrst_pe", int'(bus.periodEnd), 0);
        rst    = 1'b0;
        bus.en = 3'b000;
        ticks(2);
        bus.en = 3'b111;
        clr();
        ticks(100);
        chk("postrst_hi0", hi[0], 0);
        chk("postrst_hi1", hi[1], 0);
        chk("pwmL_tied_low", lOn, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
